// File: rtl/tube_r3_xfer_ctrl_pkg.sv
// Shared types and constants for the Tube R3 block-transfer sequencer.
package tube_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_NMI,
        ST_TUBE_RD,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_TUBE_WR,
        ST_GUARD_WAIT,
        ST_DONE
    } xfer_state_t;

    // Parasite-side address of Tube register 3 (the NMI-paced FIFO).
    localparam logic [2:0] R3_ADDR = 3'h5;

    localparam logic DIR_R3_TO_MEM = 1'b0;
    localparam logic DIR_MEM_TO_R3 = 1'b1;

    // Bytes moved per PNMI: two in V-flag mode, but never more than are left.
    function automatic logic [1:0] group_size(input logic two_byte, input logic more_than_one);
        return (two_byte && more_than_one) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/tube_r3_xfer_ctrl_if.sv
// Tube parasite bus plus local memory port, as seen by the transfer sequencer.
interface tube_r3_xfer_ctrl_if #(parameter int ADDR_W = 16) ();

    logic [2:0]        t_addr;
    logic              t_cs_b;
    logic              t_rdnw;
    logic [7:0]        t_wdata;
    logic [7:0]        t_rdata;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_wdata;
    logic [7:0]        m_rdata;
    logic              m_ack;

    modport master (
        output t_addr, t_cs_b, t_rdnw, t_wdata,
        output m_req, m_we, m_addr, m_wdata,
        input  t_rdata, m_rdata, m_ack
    );

    modport slave (
        input  t_addr, t_cs_b, t_rdnw, t_wdata,
        input  m_req, m_we, m_addr, m_wdata,
        output t_rdata, m_rdata, m_ack
    );

endinterface

// File: rtl/tube_r3_xfer_ctrl_nmi_sync.sv
// PNMI synchroniser with a post-group guard mask so a stale PNMI is not re-taken.
module tube_nmi_sync #(
    parameter int GUARD = 3
) (
    input  logic clk,
    input  logic h_rst_b,
    input  logic p_nmi_b,
    input  logic guard_load,
    output logic req,
    output logic guard_done
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    logic          nmi_meta;
    logic          nmi_s;
    logic [GW-1:0] guard_cnt;

    // Two-flop synchroniser; idles high so reset never looks like a request.
    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            nmi_meta <= 1'b1;
            nmi_s    <= 1'b1;
        end else begin
            nmi_meta <= p_nmi_b;
            nmi_s    <= nmi_meta;
        end
    end

    // Guard counter: loaded on entry to the guard window, counts down to zero.
    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            guard_cnt <= '0;
        end else if (guard_load) begin
            guard_cnt <= GW'(GUARD - 1);
        end else if (guard_cnt != '0) begin
            guard_cnt <= guard_cnt - GW'(1);
        end
    end

    assign guard_done = (guard_cnt == '0);
    assign req        = !nmi_s && guard_done;

endmodule

// File: rtl/tube_r3_xfer_ctrl.sv
// NMI-paced block-transfer sequencer between Tube R3 and a local memory port.
module tube_r3_xfer_ctrl
    import tube_xfer_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int LEN_W    = 16,
    parameter int TUBE_CYC = 2,
    parameter int GUARD    = 3
) (
    input  logic                 clk,
    input  logic                 h_rst_b,
    input  logic                 start,
    input  logic                 dir,
    input  logic                 two_byte,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     length,
    input  logic                 abort,
    input  logic                 p_nmi_b,
    tube_r3_xfer_ctrl_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     remaining
);

    localparam int CW = $clog2(TUBE_CYC + 1);

    xfer_state_t       state, next_state;
    logic              dir_l;
    logic              two_l;
    logic [1:0]        group;
    logic [CW-1:0]     cyc_cnt;
    logic [ADDR_W-1:0] m_addr_r;
    logic [7:0]        m_wdata_r;
    logic [7:0]        t_wdata_r;
    logic [LEN_W-1:0]  remaining_r;
    logic              abort_pend;
    logic              abort_eff;
    logic              tube_st;
    logic              tube_last;
    logic              advance;
    logic              guard_load;
    logic              req;
    logic              guard_done;
    xfer_state_t       after_byte;

    tube_nmi_sync #(.GUARD(GUARD)) u_sync (
        .clk        (clk),
        .h_rst_b    (h_rst_b),
        .p_nmi_b    (p_nmi_b),
        .guard_load (guard_load),
        .req        (req),
        .guard_done (guard_done)
    );

    assign tube_st   = (state == ST_TUBE_RD) || (state == ST_TUBE_WR);
    assign tube_last = (cyc_cnt == CW'(TUBE_CYC - 1));
    assign abort_eff = abort || abort_pend;

    // State register.
    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; an abort is always allowed to finish the current bus cycle first.
    always_comb begin
        next_state = state;
        advance    = 1'b0;
        after_byte = ST_GUARD_WAIT;
        if (group != 2'd1) begin
            after_byte = (dir_l == DIR_MEM_TO_R3) ? ST_MEM_RD : ST_TUBE_RD;
        end else if (remaining_r == LEN_W'(1)) begin
            after_byte = ST_DONE;
        end
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    next_state = (length == '0) ? ST_DONE : ST_WAIT_NMI;
                end
            end
            ST_WAIT_NMI: begin
                if (abort_eff) begin
                    next_state = ST_IDLE;
                end else if (req) begin
                    next_state = (dir_l == DIR_MEM_TO_R3) ? ST_MEM_RD : ST_TUBE_RD;
                end
            end
            ST_TUBE_RD: begin
                if (tube_last) begin
                    next_state = abort_eff ? ST_IDLE : ST_MEM_WR;
                end
            end
            ST_MEM_WR: begin
                if (bus.m_ack) begin
                    advance    = 1'b1;
                    next_state = abort_eff ? ST_IDLE : after_byte;
                end
            end
            ST_MEM_RD: begin
                if (bus.m_ack) begin
                    advance    = abort_eff;
                    next_state = abort_eff ? ST_IDLE : ST_TUBE_WR;
                end
            end
            ST_TUBE_WR: begin
                if (tube_last) begin
                    advance    = 1'b1;
                    next_state = abort_eff ? ST_IDLE : after_byte;
                end
            end
            ST_GUARD_WAIT: begin
                if (abort_eff) begin
                    next_state = ST_IDLE;
                end else if (guard_done) begin
                    next_state = ST_WAIT_NMI;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        guard_load = (next_state == ST_GUARD_WAIT) && (state != ST_GUARD_WAIT);
    end

    // Datapath: command latch, strobe timer, byte/address counters and data capture.
    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            dir_l       <= DIR_R3_TO_MEM;
            two_l       <= 1'b0;
            group       <= 2'd1;
            cyc_cnt     <= '0;
            m_addr_r    <= '0;
            m_wdata_r   <= '0;
            t_wdata_r   <= '0;
            remaining_r <= '0;
            abort_pend  <= 1'b0;
        end else begin
            cyc_cnt <= (tube_st && !tube_last) ? cyc_cnt + CW'(1) : '0;
            if (state == ST_IDLE) begin
                abort_pend <= 1'b0;
            end else if (abort && state != ST_DONE) begin
                abort_pend <= 1'b1;
            end
            if (state == ST_IDLE && start && !abort) begin
                dir_l       <= dir;
                two_l       <= two_byte;
                m_addr_r    <= base_addr;
                remaining_r <= length;
            end
            if (state == ST_WAIT_NMI && req && !abort_eff) begin
                group <= group_size(two_l, remaining_r > LEN_W'(1));
            end
            if (state == ST_TUBE_RD && tube_last) begin
                m_wdata_r <= bus.t_rdata;
            end
            if (state == ST_MEM_RD && bus.m_ack) begin
                t_wdata_r <= bus.m_rdata;
            end
            if (advance) begin
                m_addr_r    <= m_addr_r + ADDR_W'(1);
                remaining_r <= remaining_r - LEN_W'(1);
                group       <= group - 2'd1;
            end
        end
    end

    assign bus.t_addr  = tube_st ? R3_ADDR : 3'h0;
    assign bus.t_cs_b  = !tube_st;
    assign bus.t_rdnw  = (state != ST_TUBE_WR);
    assign bus.t_wdata = t_wdata_r;
    assign bus.m_req   = (state == ST_MEM_WR) || (state == ST_MEM_RD);
    assign bus.m_we    = (state == ST_MEM_WR);
    assign bus.m_addr  = m_addr_r;
    assign bus.m_wdata = m_wdata_r;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign remaining   = remaining_r;

endmodule
